// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked, fixed-latency, byte-addressable 16-bit data
// memory for the MEM stage. One request in flight; the response is held until
// the initiator consumes it.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Merge a new byte into one lane of a word; hi selects bits [15:8].
    function automatic logic [15:0] lane_merge(input logic [15:0] word,
                                               input logic [7:0]  data,
                                               input logic        hi);
        logic [15:0] res;
        if (hi) begin
            res = {data, word[7:0]};
        end else begin
            res = {word[15:8], data};
        end
        return res;
    endfunction

    // Extract one byte lane of a word, zero-extended to 16 bits.
    function automatic logic [15:0] lane_extract(input logic [15:0] word,
                                                 input logic        hi);
        logic [15:0] res;
        if (hi) begin
            res = {8'h00, word[15:8]};
        end else begin
            res = {8'h00, word[7:0]};
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        capture_s;
    logic        enter_resp_s;
    logic        handshake_s;

    logic        write_r;
    logic        byte_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;

    logic        op_write_s;
    logic        op_byte_s;
    logic [15:0] op_addr_s;
    logic [15:0] op_wdata_s;
    logic [AW-1:0] idx_s;
    logic        in_range_s;
    logic        acc_err_s;
    logic [15:0] cur_word_s;
    logic [15:0] wr_word_s;
    logic [15:0] acc_rdata_s;
    logic        mem_we_s;

    logic [15:0] mem_r [0:DEPTH_WORDS-1];

    logic        resp_valid_r;
    logic        busy_r;
    logic [15:0] resp_rdata_r;
    logic        resp_err_r;

    assign req_ready  = (state_r == IDLE) & ~reset;
    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Next-state and counter logic; LATENCY==1 skips WAIT and accesses on the acceptance edge.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        capture_s    = 1'b0;
        enter_resp_s = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    capture_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                        cnt_nxt_s    = 4'd0;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = LAT_M1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s  = RESP;
                    enter_resp_s = 1'b1;
                    cnt_nxt_s    = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                    handshake_s = 1'b1;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Access operands come straight from the inputs when the access happens on the acceptance edge.
    always_comb begin
        if (state_r == IDLE) begin
            op_write_s = req_write;
            op_byte_s  = req_byte;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = write_r;
            op_byte_s  = byte_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
    end

    assign idx_s      = op_addr_s[AW:1];
    assign in_range_s = ({17'd0, op_addr_s[15:1]} < 32'($unsigned(DEPTH_WORDS)));
    assign acc_err_s  = ~in_range_s | (~op_byte_s & op_addr_s[0]);
    assign cur_word_s = mem_r[idx_s];
    assign mem_we_s   = enter_resp_s & op_write_s & ~acc_err_s;

    // Store data and load result for the access performed when entering RESP.
    always_comb begin
        wr_word_s   = op_wdata_s;
        acc_rdata_s = 16'h0000;
        if (op_byte_s) begin
            wr_word_s = lane_merge(cur_word_s, op_wdata_s[7:0], op_addr_s[0]);
        end else begin
            wr_word_s = op_wdata_s;
        end
        if (acc_err_s || op_write_s) begin
            acc_rdata_s = 16'h0000;
        end else if (op_byte_s) begin
            acc_rdata_s = lane_extract(cur_word_s, op_addr_s[0]);
        end else begin
            acc_rdata_s = cur_word_s;
        end
    end

    // FSM state, latency counter and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            resp_rdata_r <= 16'h0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            resp_valid_r <= (state_nxt_s == RESP);
            busy_r       <= (state_nxt_s != IDLE);
            if (enter_resp_s) begin
                resp_rdata_r <= acc_rdata_s;
                resp_err_r   <= acc_err_s;
            end else if (handshake_s) begin
                resp_rdata_r <= 16'h0000;
                resp_err_r   <= 1'b0;
            end
        end
    end

    // Request registers keep the in-flight request independent of later input changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_r <= 1'b0;
            byte_r  <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
        end else if (capture_s) begin
            write_r <= req_write;
            byte_r  <= req_byte;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Storage array: cleared on reset, written only by an error-free store.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (mem_we_s) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table for single transactions,
// hand-written sequences for backpressure, reset mid-flight and LATENCY=1.
module tb_data_mem_responder;

    typedef struct {
        logic        wr;
        logic        bt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [15:0] req_addr = 16'h0000, req_wdata = 16'h0000;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [15:0] resp_rdata;

    logic        req_valid1 = 1'b0, req_write1 = 1'b0, req_byte1 = 1'b0;
    logic [15:0] req_addr1 = 16'h0000, req_wdata1 = 16'h0000;
    logic        req_ready1, resp_valid1, resp_err1, busy1;
    logic [15:0] resp_rdata1;

    int total = 0;
    int bad   = 0;

    vec_t vecs [16];
    vec_t seq1 [4];

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_byte(req_byte1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(1'b1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance, checked against the vector.
    task automatic run_req(input vec_t v, input string tag);
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = v.wr;
        req_byte  = v.bt;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_byte  = ~v.bt;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd2);
        chk({tag, ".rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
        chk({tag, ".err"}, 32'(resp_err), 32'(v.exp_err));
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".post_valid"}, {resp_valid, busy, req_ready}, 32'b001);
        chk({tag, ".post_data"}, {15'd0, resp_err, resp_rdata}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0021, 16'hFFAB, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hAB34, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0034, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'h00AB, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0201, 16'hFFFF, 16'h0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0200, 16'hFFFF, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'h01FF, 16'h0077, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h01FE, 16'h0000, 16'h7700, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0000, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 16'h0002, 16'hA5A5, 16'h0000, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'h0002, 16'h113C, 16'h0000, 1'b0};

        seq1[0] = '{1'b1, 1'b0, 16'h0006, 16'h1111, 16'h0000, 1'b0};
        seq1[1] = '{1'b0, 1'b0, 16'h0006, 16'h0000, 16'h1111, 1'b0};
        seq1[2] = '{1'b1, 1'b1, 16'h0007, 16'h0022, 16'h0000, 1'b0};
        seq1[3] = '{1'b0, 1'b0, 16'h0006, 16'h0000, 16'h2211, 1'b0};

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset.ready_low", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset.ready", 32'(req_ready), 32'd1);
        chk("reset.outs", {resp_valid, busy, resp_err, resp_rdata}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end
        run_req('{1'b0, 1'b0, 16'h0002, 16'h0000, 16'hA53C, 1'b0}, "lane_merge");

        // backpressure: response held 5 cycles, pending request not accepted
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
        @(posedge clock);
        #1;
        req_addr = 16'h0020;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("bp.latency", 32'(n), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp.hold%0d", c), {resp_valid, req_ready, resp_err, resp_rdata},
                {1'b1, 1'b0, 1'b0, 16'hBEEF});
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        chk("bp.after_hs", {resp_valid, busy, req_ready}, 32'b001);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("bp.accepted", 32'(busy), 32'd1);
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("bp.lat2", 32'(n), 32'd2);
        chk("bp.rdata2", 32'(resp_rdata), 32'hAB34);
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;

        // reset while WAIT
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 16'h0004; req_wdata = 16'h5555;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("rst.in_wait", {busy, resp_valid}, 32'b10);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst.outs", {resp_valid, busy, req_ready, resp_err, resp_rdata}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        run_req('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0}, "rst.load");

        // reset while a response is held
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0003;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rst2.held", {resp_valid, resp_err}, 32'b11);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst2.dropped", {resp_valid, busy, resp_err, resp_rdata}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // LATENCY=1 instance, back-to-back with resp_ready tied high
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_valid1 = 1'b1;
            req_write1 = seq1[i].wr;
            req_byte1  = seq1[i].bt;
            req_addr1  = seq1[i].addr;
            req_wdata1 = seq1[i].wdata;
            chk($sformatf("l1.ready%0d", i), 32'(req_ready1), 32'd1);
            @(posedge clock);
            #1;
            chk($sformatf("l1.resp%0d", i), {resp_valid1, req_ready1, resp_err1, resp_rdata1},
                {1'b1, 1'b0, seq1[i].exp_err, seq1[i].exp_rdata});
            @(posedge clock);
            #1;
            chk($sformatf("l1.idle%0d", i), {resp_valid1, busy1, resp_rdata1}, 32'd0);
        end
        req_valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
